// File: rtl/mode_select_sync_if.sv
// Button/mode bundle between the board-side stimulus (master) and the selector (slave).
interface mode_select_sync_if #(
  parameter int unsigned NUM_BUTTONS = 4
);
  localparam int unsigned MODE_W = $clog2(NUM_BUTTONS);

  logic [NUM_BUTTONS-1:0] buttons_i;
  logic                   lock_i;
  logic [MODE_W-1:0]      mode_o;
  logic                   mode_changed_o;
  logic [NUM_BUTTONS-1:0] press_o;
  logic [NUM_BUTTONS-1:0] buttons_db_o;

  modport master (
    output buttons_i, lock_i,
    input  mode_o, mode_changed_o, press_o, buttons_db_o
  );

  modport slave (
    input  buttons_i, lock_i,
    output mode_o, mode_changed_o, press_o, buttons_db_o
  );
endinterface

// File: rtl/mode_select_sync.sv
// Push-button mode selector: per-button sync + debounce, rising-edge detect,
// fixed-priority mode register with change strobe and lock.
module mode_select_sync #(
  parameter int unsigned NUM_BUTTONS     = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned RESET_MODE      = 0,
  localparam int unsigned MODE_W         = $clog2(NUM_BUTTONS)
) (
  input  logic              clk,
  input  logic              rst,
  mode_select_sync_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [MODE_W-1:0] MODE_RST = MODE_W'(RESET_MODE);

  logic [NUM_BUTTONS-1:0] s1_q, s2_q;
  logic [NUM_BUTTONS-1:0] db_q, db_d;
  logic [NUM_BUTTONS-1:0] dbd_q;
  logic [CNT_W-1:0]       cnt_q [NUM_BUTTONS];
  logic [CNT_W-1:0]       cnt_d [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] rise;
  logic [NUM_BUTTONS-1:0] press_q;
  logic [MODE_W-1:0]      mode_q, mode_d, cand;
  logic                   changed_q, changed_d;

  // Count only while the synchronised level disagrees with db; any agreement restarts.
  always_comb begin
    db_d = db_q;
    for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) db_d[i] = s2_q[i];
        else                      cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  assign rise = db_q & ~dbd_q;

  // Ascending scan so the highest-index rising button overrides lower ones.
  always_comb begin
    cand = mode_q;
    for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
      if (rise[i]) cand = MODE_W'(NUM_BUTTONS - 1 - i);
    end
    mode_d    = mode_q;
    changed_d = 1'b0;
    if ((|rise) && !bus.lock_i) begin
      mode_d    = cand;
      changed_d = (cand != mode_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      db_q      <= '0;
      dbd_q     <= '0;
      press_q   <= '0;
      mode_q    <= MODE_RST;
      changed_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_BUTTONS; i++) cnt_q[i] <= '0;
    end else begin
      s1_q      <= bus.buttons_i;
      s2_q      <= s1_q;
      db_q      <= db_d;
      dbd_q     <= db_q;
      press_q   <= rise;
      mode_q    <= mode_d;
      changed_q <= changed_d;
      for (int unsigned i = 0; i < NUM_BUTTONS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.mode_o         = mode_q;
  assign bus.mode_changed_o = changed_q;
  assign bus.press_o        = press_q;
  assign bus.buttons_db_o   = db_q;

endmodule

// File: doc/mode_select_sync.md
# mode_select_sync

Clocked, parametrised mode selector that turns N raw push-button inputs into a registered operating mode. Each button is synchronised and debounced, and only its rising edge is detected. A fixed priority encoder maps presses to a mode index that is held until the next valid press. It sits between the board button pins and the mode-dependent datapath and display logic. It adds what a purely combinational selector lacks: debounce, edge-based selection, a mode-change strobe and a lock input.

## Interface
- NUM_BUTTONS, 4: number of button inputs; minimum 2.
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before a debounced level flips; minimum 1.
- RESET_MODE, 0: mode loaded on reset; must be < NUM_BUTTONS.
- MODE_W, derived: $clog2(NUM_BUTTONS); not user-set.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- buttons_i  in  NUM_BUTTONS  raw asynchronous button levels, active-high.
- lock_i  in  1  synchronous; while high, presses do not change the mode.
- mode_o  out  MODE_W  current mode, registered.
- mode_changed_o  out  1  one-cycle pulse in the first cycle mode_o holds a new, different value.
- press_o  out  NUM_BUTTONS  one-cycle pulse per button on its debounced rising edge.
- buttons_db_o  out  NUM_BUTTONS  debounced button levels.

## Operation
- Per button, a 2-flop synchroniser (s1, s2) feeds a debounce counter (width $clog2(DEBOUNCE_CYCLES+1)) and a debounced level `db`.
- Debounce rules:
  - If s2 == db: counter clears to 0.
  - If s2 != db and counter == DEBOUNCE_CYCLES-1: db flips and counter clears.
  - Otherwise: counter increments.
  - Any return of s2 to db before the flip discards the count.
- Edge detect: rise[i] = db[i] & ~db_q[i], where db_q is db delayed one cycle. press_o = rise, registered.
- Mode mapping: button[i] → mode NUM_BUTTONS-1-i. Highest index has highest priority (button[N-1] → mode 0, button[0] → mode N-1).
- On any cycle with rise != 0 and lock_i == 0, the highest-index rising button selects the candidate mode, which loads into mode_o at the next edge.
- Selection is edge-based. A held higher-priority button does not block a later rise on a lower-priority button. Releases never change the mode.
- mode_changed_o asserts only if the loaded candidate differs from the previous mode_o. Re-selecting the current mode produces press_o but no mode_changed_o.
- lock_i == 1: rises are ignored for mode purposes and are not queued. press_o and buttons_db_o still operate. Releasing lock while a button is still held does not select.
- Reset values:
  - mode_o = RESET_MODE; mode_changed_o = 0; press_o = 0; buttons_db_o = 0.
  - All synchroniser flops, db_q and counters are 0.

## Timing
- Raw button first sampled high at edge 0 and held:
  - s2 = 1 after edge 1.
  - db flips at edge DEBOUNCE_CYCLES+1.
  - press_o is high during the cycle after edge DEBOUNCE_CYCLES+2.
  - mode_o updates at edge DEBOUNCE_CYCLES+2; mode_changed_o is high for that same cycle.
- Release has the same DEBOUNCE_CYCLES+1 latency to buttons_db_o; no press_o is generated.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no output activity.
- Simultaneous rises in one cycle: the single highest-index button wins; one mode_changed_o pulse at most. All rising bits still pulse in press_o.
- lock_i is sampled in the same cycle as rise.
- rst asserted mid-debounce or mid-press clears all state within that edge. A button still held after rst deasserts is treated as a fresh press: mode updates DEBOUNCE_CYCLES+2 edges after the first post-reset sample.
- No combinational path from inputs to outputs.

## Test plan
- Reset: N=4, D=4, RESET_MODE=0, rst high 2 cycles → mode_o=0, mode_changed_o=0, press_o=0, buttons_db_o=0.
- Clean press: button[1] raised at edge 0 and held 10 cycles → press_o[1] and mode_changed_o high exactly one cycle after edge 6; mode_o=2 from edge 6; buttons_db_o[1]=1 from edge 5.
- Bounce: button[0] toggled every 2 cycles for 12 cycles, then low → no press_o, mode_o unchanged, buttons_db_o[0] stays 0.
- Priority and edge behaviour:
  - Buttons[2] and [0] rise in the same cycle → mode_o=1, press_o=4'b0101, single mode_changed_o pulse.
  - With button[3] held, button[0] then rises → mode_o=3.
- Lock: lock_i=1, press button[3] from mode 2 → press_o[3] pulses, mode_o stays 2, no mode_changed_o. Drop lock_i while button[3] is held → mode_o stays 2.
- Re-select and reset: press the button for the current mode → press_o pulse, no mode_changed_o. Assert rst 3 cycles into debounce of button[2] while it stays held → mode_o=RESET_MODE after reset; mode_o becomes 1 exactly D+2 edges after the first post-reset sample.
